spram_fifo_ctrl: RTL
====================

# spram_fifo_ctrl

Parametrised FIFO controller built on a single-port RAM and driven by the packed instruction word `{WE, RE, DI}`. It generalises the 32-bit single-port FIFO in width and depth and adds several features: a per-cycle occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow errors, and a one-entry write-hold buffer that resolves simultaneous read and write on the single RAM port. It sits between an instruction source and a downstream consumer.

## Interface
Parameters:
- `WIDTH`, 32, data width; instruction width is `WIDTH+2`.
- `DEPTH`, 16, number of entries; power of two, ≥4.
- `AF_THRESH`, `DEPTH-2`, `almost_full` asserts when count ≥ this value.
- `AE_THRESH`, 2, `almost_empty` asserts when count ≤ this value.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `inst`  in  WIDTH+2  instruction word: bit WIDTH+1 = WE, bit WIDTH = RE, bits WIDTH-1:0 = DI.
- `err_clr`  in  1  clears `overflow` and `underflow`.
- `ready`  out  1  instruction accepted this cycle when high.
- `DO`  out  WIDTH  read data.
- `read_valid`  out  1  one-cycle pulse; `DO` is valid while it is high.
- `full`, `empty`, `almost_full`, `almost_empty`  out  1 each  status flags.
- `count`  out  clog2(DEPTH)+1  occupancy, including any held write.
- `overflow`, `underflow`  out  1 each  sticky error flags.

## Operation
- Storage is a RAM array with one access per cycle. Write pointer `wp` and read pointer `rp` are each clog2(DEPTH) bits and wrap modulo DEPTH.
- An instruction is accepted only when `ready`=1. When `ready`=0, `inst` is ignored and the source must hold its operation.
- Accepted cases:
  - **WE only, count<DEPTH:** RAM[wp]←DI; `wp`++; `count`++.
  - **WE only, count==DEPTH:** the write is dropped and `overflow`←1.
  - **RE only, count>0:** read RAM[rp]; `rp`++; `count`--.
  - **RE only, count==0:** the read is dropped, `underflow`←1, and no `read_valid`.
  - **WE&RE, count>0:** the read takes the RAM port. DI is latched into the hold buffer (`hold_v`←1) and `count` is unchanged. This is legal when full; the write does not overflow.
  - **WE&RE, count==0:** the read underflows (`underflow`←1); the write proceeds as WE only.
- Hold commit:
  - In the cycle after `hold_v` is set, `ready`=0.
  - RAM[wp]←hold data; `wp`++; `hold_v`←0.
- `err_clr`=1 clears both error flags. A same-cycle error wins, so the flag stays 1.
- Flags are registered and derived from the next-state count:
  - `full` = count==DEPTH
  - `empty` = count==0
  - `almost_full` = count≥AF_THRESH
  - `almost_empty` = count≤AE_THRESH
- `DO` holds its last read value until the next successful read.

## Timing
- **Reset (rst=1 at a clk edge):**
  - `wp`=`rp`=0, `count`=0, `hold_v`=0, `ready`=1.
  - `DO`=0, `read_valid`=0.
  - `full`=0, `empty`=1, `almost_full`=0, `almost_empty`=1.
  - `overflow`=0, `underflow`=0.
  - RAM contents are not reset.
- Reset during a held write discards the held data.
- Read latency is 1 cycle: a read accepted at edge N gives `DO` and `read_valid`=1 after edge N+1; `read_valid` falls the following cycle unless another read is accepted.
- `count` and all flags update at the same edge that accepts the operation.
- A held write commits at edge N+1. `ready` is low during the cycle between edges N and N+1 and returns high after N+1.
- Sustained throughput is one operation per cycle. A WE&RE pair costs 2 cycles.

## Test plan
- **Reset:** hold rst=1 for 3 cycles -> every output at its listed reset value, `empty`=1, `ready`=1.
- **Fill and drain (DEPTH=16):** 16 writes of 0x1000+i -> `full`=1, `almost_full` first seen at count=14. Then 16 reads -> `DO` = 0x1000..0x100F in order, `read_valid` 1 cycle after each read, `empty`=1 at the end.
- **Wrap-around:** 3 rounds of 10 writes then 10 reads with random data -> FIFO order preserved across pointer wrap, `count` returns to 0 after each round.
- **Simultaneous ops when full:** with the FIFO full, issue WE&RE with DI=0xDEADBEEF -> oldest entry read, `ready`=0 for the next cycle, `count` stays 16, no `overflow`. Draining then returns 0xDEADBEEF last.
- **Errors:**
  - 17th write when full -> `overflow`=1, `count`=16.
  - RE when empty -> `underflow`=1, no `read_valid`.
  - Assert `err_clr` -> both flags clear.
  - WE&RE when empty -> `underflow`=1 and `count`=1.
- **Reset mid-operation:** with count=7 and `hold_v`=1, assert rst -> `count`=0, `empty`=1, `ready`=1. A subsequent write/read returns the new data only.

Source files
------------

// File: rtl/spram_fifo_ctrl_if.sv
// Purpose: instruction/status bundle between an instruction source and spram_fifo_ctrl.
// Latency: none, wires only.
// Backpressure: the source holds inst while ready is low.
interface spram_fifo_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH+1:0] inst;        // {WE, RE, DI}
    logic             err_clr;
    logic             ready;
    logic [WIDTH-1:0] DO;
    logic             read_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    // Instruction source side.
    modport master (
        output inst, err_clr,
        input  ready, DO, read_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    // FIFO controller side.
    modport slave (
        input  inst, err_clr,
        output ready, DO, read_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/spram_fifo_ctrl.sv
// Purpose: FIFO controller on a single-port RAM with a one-entry write-hold buffer.
// Latency: read accepted at edge N presents DO/read_valid after edge N+1; flags update at the accept edge.
// Backpressure: ready drops for one cycle after a WE&RE pair while the held write commits.
module spram_fifo_ctrl #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic               clk,
    input  logic               rst,
    spram_fifo_ctrl_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // ST_COMMIT is the cycle in which the held write owns the RAM port.
    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_COMMIT = 1'b1
    } state_t;

    state_t           state_q, state_d;

    // Storage: one access per cycle through ram_addr.
    logic [WIDTH-1:0] mem [DEPTH];
    logic             ram_we;
    logic             ram_re;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_wdat;
    logic [WIDTH-1:0] rd_dat_q;

    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] hold_dat_q;
    logic             hold_ld;
    logic             hold_v;

    logic             rd_acc;
    logic             rd_pend_q;
    logic [WIDTH-1:0] do_q;
    logic             rv_q;

    logic             full_q, empty_q, af_q, ae_q;
    logic             ovf_q, unf_q;
    logic             ovf_set, unf_set;

    logic             op_we;
    logic             op_re;
    logic [WIDTH-1:0] op_di;
    logic             is_full;
    logic             is_empty;

    assign op_we    = bus.inst[WIDTH+1];
    assign op_re    = bus.inst[WIDTH];
    assign op_di    = bus.inst[WIDTH-1:0];
    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);
    assign hold_v   = (state_q == ST_COMMIT);

    // Next-state and RAM port arbitration: decode the accepted instruction or commit the held write.
    always_comb begin
        state_d  = state_q;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = wp_q;
        ram_wdat = op_di;
        wp_d     = wp_q;
        rp_d     = rp_q;
        count_d  = count_q;
        hold_ld  = 1'b0;
        rd_acc   = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (op_we && op_re) begin
                    if (!is_empty) begin
                        // Read wins the port; the write waits one cycle in the hold buffer.
                        ram_re   = 1'b1;
                        ram_addr = rp_q;
                        rp_d     = rp_q + 1'b1;
                        rd_acc   = 1'b1;
                        hold_ld  = 1'b1;
                        state_d  = ST_COMMIT;
                    end else begin
                        // Nothing to read: flag it and let the write go straight in.
                        unf_set  = 1'b1;
                        ram_we   = 1'b1;
                        ram_addr = wp_q;
                        wp_d     = wp_q + 1'b1;
                        count_d  = count_q + 1'b1;
                    end
                end else if (op_we) begin
                    if (!is_full) begin
                        ram_we   = 1'b1;
                        ram_addr = wp_q;
                        wp_d     = wp_q + 1'b1;
                        count_d  = count_q + 1'b1;
                    end else begin
                        ovf_set  = 1'b1;
                    end
                end else if (op_re) begin
                    if (!is_empty) begin
                        ram_re   = 1'b1;
                        ram_addr = rp_q;
                        rp_d     = rp_q + 1'b1;
                        rd_acc   = 1'b1;
                        count_d  = count_q - 1'b1;
                    end else begin
                        unf_set  = 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                // inst is ignored here; count already includes the held entry.
                ram_we   = 1'b1;
                ram_addr = wp_q;
                ram_wdat = hold_dat_q;
                wp_d     = wp_q + 1'b1;
                state_d  = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Single-port RAM: either one write or one registered read per cycle, never both.
    always_ff @(posedge clk) begin
        if (!rst && ram_we) begin
            mem[ram_addr] <= ram_wdat;
        end else if (!rst && ram_re) begin
            rd_dat_q <= mem[ram_addr];
        end
    end

    // Control state, pointers, occupancy and hold buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            hold_dat_q <= '0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            if (hold_ld) begin
                hold_dat_q <= op_di;
            end
        end
    end

    // Read return pipeline: RAM output register, then DO which holds until the next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q <= 1'b0;
            do_q      <= '0;
            rv_q      <= 1'b0;
        end else begin
            rd_pend_q <= rd_acc;
            rv_q      <= rd_pend_q;
            if (rd_pend_q) begin
                do_q <= rd_dat_q;
            end
        end
    end

    // Status flags registered from the next-state count so they move with count.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
            af_q    <= (count_d >= CW'(AF_THRESH));
            ae_q    <= (count_d <= CW'(AE_THRESH));
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_set | (ovf_q & ~bus.err_clr);
            unf_q <= unf_set | (unf_q & ~bus.err_clr);
        end
    end

    assign bus.ready        = ~hold_v;
    assign bus.DO           = do_q;
    assign bus.read_valid   = rv_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule
